// File: rtl/mtm_alu_pkg.sv
// Shared MTM ALU types, frame constants and the CRC3 helper.
// Used by the serializer and the ALU core.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TYPE,
    DATA,
    STOP
  } ser_state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic TYPE_DATA  = 1'b0;
  localparam logic TYPE_CTL   = 1'b1;

  localparam logic [7:0] ERR_DATA  = 8'hC9;
  localparam logic [7:0] ERR_CRC   = 8'hA5;
  localparam logic [7:0] ERR_OP    = 8'h93;
  localparam logic [7:0] NO_RESULT = 8'hFF;

  // x^3+x+1, init 000, d[35] shifted in first
  function automatic logic [2:0] mtm_crc3(
    input logic [35:0] d
  );
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 35; i >= 0; i--) begin
      fb  = crc[2] ^ d[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result handshake between the ALU core and the serializer.
// The core drives C/CTL/in_valid; the serializer answers in_ready.
interface mtm_alu_serializer_if;
  logic [31:0] C;
  logic [7:0]  CTL;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output C,
    output CTL,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  C,
    input  CTL,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/mtm_alu_bit_timer.sv
// Bit-period tick generator: one tick every CLK_PER_BIT cycles while run=1.
// The counter is held at 0 whenever run is low so each packet starts aligned.
module mtm_alu_bit_timer #(
  parameter int CLK_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int W =
    (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU transmit serializer: C/CTL packets as 11-bit frames on sout.
// Optional CRC check of normal packets with macro MTM_SER_CRC_CHECK_EN.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int CLK_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mtm_alu_serializer_if.slave  bus,
  output logic                 sout,
  output logic                 crc_err
);

  ser_state_t  state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  frame_q, frame_d;
  logic [31:0] c_q, c_d;
  logic [7:0]  ctl_q, ctl_d;
  logic [7:0]  payload;
  logic        sout_d;
  logic        tick;
  logic        accept;

  assign bus.in_ready = (state_q == IDLE);
  assign accept = bus.in_valid
               && (state_q == IDLE)
               && (bus.CTL != NO_RESULT);

  mtm_alu_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q != IDLE),
    .tick (tick)
  );

`ifdef MTM_SER_CRC_CHECK_EN
  logic crc_bad;
  assign crc_bad = !bus.CTL[7]
    && (mtm_crc3({bus.C, bus.CTL[6:3]})
        != bus.CTL[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err <= 1'b0;
    end else begin
      crc_err <= accept && crc_bad;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    c_d     = c_q;
    ctl_d   = ctl_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        c_d     = bus.C;
        ctl_d   = bus.CTL;
        // error codes skip straight to the control frame
        frame_d = bus.CTL[7] ? 3'd4 : 3'd0;
`ifdef MTM_SER_CRC_CHECK_EN
        if (crc_bad) begin
          ctl_d   = ERR_CRC;
          frame_d = 3'd4;
        end
`endif
      end
      START: if (tick) state_d = TYPE;
      TYPE: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd7;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd0) state_d = STOP;
        else bit_d = bit_q - 3'd1;
      end
      STOP: if (tick) begin
        if (frame_q == 3'd4) begin
          state_d = IDLE;
          frame_d = 3'd0;
        end else begin
          state_d = START;
          frame_d = frame_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    payload = ctl_d;
    unique case (1'b1)
      (frame_d == 3'd0): payload = c_d[31:24];
      (frame_d == 3'd1): payload = c_d[23:16];
      (frame_d == 3'd2): payload = c_d[15:8];
      (frame_d == 3'd3): payload = c_d[7:0];
      default:           payload = ctl_d;
    endcase
  end

  // sout is registered from the next-state view so it stays glitch-free
  always_comb begin
    sout_d = 1'b1;
    unique case (state_d)
      IDLE:    sout_d = 1'b1;
      START:   sout_d = 1'b0;
      TYPE:    sout_d = (frame_d == 3'd4) ? TYPE_CTL
                                          : TYPE_DATA;
      DATA:    sout_d = payload[bit_d];
      STOP:    sout_d = 1'b1;
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      frame_q <= 3'd0;
      c_q     <= '0;
      ctl_q   <= '0;
      sout    <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      c_q     <= c_d;
      ctl_q   <= ctl_d;
      sout    <= sout_d;
    end
  end

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
- Transmit end of the MTM ALU serial link. Takes one result word C[31:0] and one status byte CTL[7:0] per operation from mtm_Alu_core.
- Serialises them onto the single-wire output sout as 11-bit frames.
- Sits between mtm_Alu_core and the chip output pad. The counterpart of the input deserializer.

Parameters:
- CLK_PER_BIT, 1, clock cycles per serial bit; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- C  input  32  result word from the ALU core.
- CTL  input  8  status/control byte from the ALU core.
- in_valid  input  1  C/CTL valid this cycle.
- in_ready  output  1  serializer idle and able to accept.
- sout  output  1  serial line; idle level 1.
- crc_err  output  1  one-cycle pulse on CRC mismatch (MTM_SER_CRC_CHECK_EN only; tied 0 otherwise).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: sout=1, in_ready=1, crc_err=0, FSM=IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately; no resume.
- Frame format, 11 bits, in order:
  - start bit 0;
  - type bit (0 = data byte, 1 = control byte);
  - 8 payload bits, MSB first;
  - stop bit 1.
- Accept: occurs on a rising edge with in_valid=1, in_ready=1 and CTL!=8'hFF.
  - C and CTL are registered internally at that edge.
  - CTL=8'hFF with in_valid is a "no result" marker: not accepted, nothing sent, in_ready stays 1.
- Packet selection on the captured CTL:
  - CTL[7]=0 (normal result): 4 data frames C[31:24], C[23:16], C[15:8], C[7:0], then 1 control frame CTL. 55 bits, back-to-back, no idle between frames.
  - CTL[7]=1 (error code, e.g. 8'hC9, 8'hA5, 8'h93): the control frame CTL only. 11 bits.
- Timing:
  - The start bit of the first frame appears on sout in the cycle after the accept edge.
  - Each bit is held exactly CLK_PER_BIT cycles.
  - in_ready falls in the same cycle the start bit appears.
  - in_ready rises, with sout=1, in the cycle after the last stop-bit period ends.
  - Minimum inter-packet gap: 1 idle cycle.
- FSM states: IDLE, START, TYPE, DATA, STOP.
  - IDLE -> START on accept.
  - START -> TYPE -> DATA.
  - DATA holds for 8 bits, indexed by bit_cnt 7..0.
  - DATA -> STOP.
  - STOP -> START if frames remain, else IDLE.
- Counters: bit-period counter 0..CLK_PER_BIT-1; bit_cnt 3 bits; frame_cnt 0..4. frame_cnt starts at 4 for error packets so that only the control frame is sent.
- sout is a flop output (glitch-free).
- in_valid and input changes while busy are ignored; nothing is queued.

Optional Feature:
- Macro: MTM_SER_CRC_CHECK_EN.
- With the macro:
  - At accept, for normal packets, recompute the CRC with mtm_crc3 over {C, CTL[6:3]}.
  - If the result differs from CTL[2:0], replace the packet with the single control frame ERR_CRC (8'hA5).
  - Pulse crc_err for one cycle, in the cycle after accept.
- Without the macro: no check, CTL is sent as received, and crc_err is tied 0.

Decomposition:
- Package mtm_alu_pkg holds:
  - FSM state enum;
  - frame constants: FRAME_BITS=11, TYPE_DATA=0, TYPE_CTL=1;
  - error codes ERR_DATA=8'hC9, ERR_CRC=8'hA5, ERR_OP=8'h93, NO_RESULT=8'hFF;
  - function mtm_crc3: 36-bit data, polynomial x^3+x+1, init 000, first serial bit d[35]. Shared with the core.
- Optional sub-module mtm_alu_bit_timer: the CLK_PER_BIT tick generator.

Test Plan:
- C=32'h12345678, CTL=8'h08, CLK_PER_BIT=1 -> 55 bits.
  - Frame 1: 0,0,00010010,1. Frame 5: 0,1,00001000,1.
  - in_ready low for exactly 55 cycles.
- CTL=8'hC9 -> single frame 0,1,11001001,1; in_ready=1 at cycle 12 after accept.
- in_valid with CTL=8'hFF -> sout stays 1, in_ready stays 1 for 20 cycles.
- CLK_PER_BIT=4, C=32'hFFFF0000, CTL=8'h0A -> every bit held 4 cycles, 220 busy cycles; in_valid pulses mid-packet are ignored.
- rst_n low at bit 30 of a normal packet -> sout=1 and in_ready=1 asynchronously. After release, a new accept starts cleanly with a start bit.
- MTM_SER_CRC_CHECK_EN, CTL[2:0] flipped from the mtm_crc3 value -> crc_err pulse, then single frame 0,1,10100101,1. A correct CRC sends the full 55 bits.
